// File: rtl/ahb_uart_cfg.sv
// AHB-Lite UART with programmable baud divisor, parity, 1/2 stop bits, TX/RX FIFOs,
// sticky error flags and a masked level interrupt. Never inserts wait states.
module ahb_uart_cfg #(
  parameter int          FIFO_AW     = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd26
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  input  logic        RsRx,
  output logic        RsTx,
  output logic        uart_irq
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT} rx_state_t;

  logic        dp_valid, dp_write;
  logic [1:0]  dp_addr;
  logic        wr_data, wr_stat, wr_ctrl, wr_baud, rd_data;
  logic [7:0]  ctrl;
  logic [15:0] bauddiv, baud_cnt;
  logic        tick;
  logic        par_en, par_odd;
  logic [3:0]  sticky, sticky_set, sticky_clr;
  logic [8:0]  status;

  logic [7:0]         tx_mem [DEPTH];
  logic [FIFO_AW:0]   tx_wp, tx_rp;
  logic               tx_empty, tx_full, tx_push, tx_pop;
  logic [7:0]         rx_mem [DEPTH];
  logic [FIFO_AW:0]   rx_wp, rx_rp;
  logic               rx_empty, rx_full, rx_push, rx_pop, rx_push_ok;

  tx_state_t   tx_state, tx_state_n;
  logic [3:0]  tx_tcnt, tx_tcnt_n;
  logic [2:0]  tx_bit, tx_bit_n;
  logic        tx_stop2, tx_stop2_n;
  logic [7:0]  tx_byte, tx_byte_n;
  logic        tx_busy, tx_can_start, tx_bit_end;

  rx_state_t   rx_state, rx_state_n;
  logic [3:0]  rx_tcnt, rx_tcnt_n;
  logic [2:0]  rx_bit, rx_bit_n;
  logic [7:0]  rx_shift, rx_shift_n;
  logic        rx_meta, rx_sync, rx_bit_end;
  logic        rx_set_frame, rx_set_parity;

  logic unused_bits;
  assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HWDATA[31:16]};

  assign HREADYOUT = 1'b1;

  // Address phase is latched so the data phase can act on it one cycle later.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= 2'd0;
    end else if (HREADY) begin
      dp_valid <= HSEL & HTRANS[1];
      dp_write <= HWRITE;
      dp_addr  <= HADDR[3:2];
    end
  end

  assign wr_data = dp_valid & dp_write & (dp_addr == 2'd0);
  assign wr_stat = dp_valid & dp_write & (dp_addr == 2'd1);
  assign wr_ctrl = dp_valid & dp_write & (dp_addr == 2'd2);
  assign wr_baud = dp_valid & dp_write & (dp_addr == 2'd3);
  assign rd_data = dp_valid & !dp_write & (dp_addr == 2'd0);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ctrl    <= 8'h03;
      bauddiv <= DEFAULT_DIV;
    end else begin
      if (wr_ctrl) ctrl <= HWDATA[7:0];
      if (wr_baud) bauddiv <= HWDATA[15:0];
    end
  end

  assign par_en  = ctrl[3] ^ ctrl[2];
  assign par_odd = ctrl[3];

  // Rewriting the divisor restarts the count so the new rate takes effect at once.
  assign tick = (baud_cnt == bauddiv);
  always_ff @(posedge HCLK) begin
    if (HRESET || wr_baud) baud_cnt <= 16'd0;
    else if (tick)         baud_cnt <= 16'd0;
    else                   baud_cnt <= baud_cnt + 16'd1;
  end

  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[FIFO_AW] != tx_rp[FIFO_AW]) &&
                    (tx_wp[FIFO_AW-1:0] == tx_rp[FIFO_AW-1:0]);
  assign tx_push  = wr_data & !tx_full;

  always_ff @(posedge HCLK) begin
    if (tx_push) tx_mem[tx_wp[FIFO_AW-1:0]] <= HWDATA[7:0];
    if (rx_push_ok) rx_mem[rx_wp[FIFO_AW-1:0]] <= rx_shift_n;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      tx_wp <= '0;
      tx_rp <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (tx_push)    tx_wp <= tx_wp + 1'b1;
      if (tx_pop)     tx_rp <= tx_rp + 1'b1;
      if (rx_push_ok) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)     rx_rp <= rx_rp + 1'b1;
    end
  end

  assign rx_empty   = (rx_wp == rx_rp);
  assign rx_full    = (rx_wp[FIFO_AW] != rx_rp[FIFO_AW]) &&
                      (rx_wp[FIFO_AW-1:0] == rx_rp[FIFO_AW-1:0]);
  assign rx_pop     = rd_data & !rx_empty;
  assign rx_push_ok = rx_push & (!rx_full | rx_pop);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      tx_state <= TX_IDLE;
      tx_tcnt  <= 4'd0;
      tx_bit   <= 3'd0;
      tx_stop2 <= 1'b0;
      tx_byte  <= 8'd0;
    end else begin
      tx_state <= tx_state_n;
      tx_tcnt  <= tx_tcnt_n;
      tx_bit   <= tx_bit_n;
      tx_stop2 <= tx_stop2_n;
      tx_byte  <= tx_byte_n;
    end
  end

  assign tx_can_start = ctrl[0] & !tx_empty;
  assign tx_bit_end   = tick & (tx_tcnt == 4'd15);
  assign tx_busy      = (tx_state != TX_IDLE);

  // A frame only starts on a tick; STOP chains straight into START for back-to-back bytes.
  always_comb begin
    tx_state_n = tx_state;
    tx_tcnt_n  = tx_tcnt;
    tx_bit_n   = tx_bit;
    tx_stop2_n = tx_stop2;
    tx_byte_n  = tx_byte;
    tx_pop     = 1'b0;
    if (tick && tx_state != TX_IDLE) tx_tcnt_n = tx_tcnt + 4'd1;
    case (tx_state)
      TX_IDLE: if (tick && tx_can_start) begin
        tx_state_n = TX_START;
        tx_tcnt_n  = 4'd0;
        tx_pop     = 1'b1;
        tx_byte_n  = tx_mem[tx_rp[FIFO_AW-1:0]];
      end
      TX_START: if (tx_bit_end) begin
        tx_state_n = TX_DATA;
        tx_bit_n   = 3'd0;
      end
      TX_DATA: if (tx_bit_end) begin
        if (tx_bit == 3'd7) begin
          tx_state_n = par_en ? TX_PARITY : TX_STOP;
          tx_stop2_n = 1'b0;
        end else begin
          tx_bit_n = tx_bit + 3'd1;
        end
      end
      TX_PARITY: if (tx_bit_end) begin
        tx_state_n = TX_STOP;
        tx_stop2_n = 1'b0;
      end
      TX_STOP: if (tx_bit_end) begin
        if (ctrl[4] && !tx_stop2) begin
          tx_stop2_n = 1'b1;
        end else if (tx_can_start) begin
          tx_state_n = TX_START;
          tx_pop     = 1'b1;
          tx_byte_n  = tx_mem[tx_rp[FIFO_AW-1:0]];
        end else begin
          tx_state_n = TX_IDLE;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  always_comb begin
    case (tx_state)
      TX_START:  RsTx = 1'b0;
      TX_DATA:   RsTx = tx_byte[tx_bit];
      TX_PARITY: RsTx = (^tx_byte) ^ par_odd;
      default:   RsTx = 1'b1;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_tcnt  <= 4'd0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'd0;
    end else begin
      rx_meta  <= RsRx;
      rx_sync  <= rx_meta;
      rx_state <= rx_state_n;
      rx_tcnt  <= rx_tcnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end

  assign rx_bit_end = tick & (rx_tcnt == 4'd15);

  // Sampling is centred by waiting half a bit after the falling edge; a bad stop bit
  // parks in RX_WAIT so a held-low line is not mistaken for a new start bit.
  always_comb begin
    rx_state_n    = rx_state;
    rx_tcnt_n     = rx_tcnt;
    rx_bit_n      = rx_bit;
    rx_shift_n    = rx_shift;
    rx_push       = 1'b0;
    rx_set_frame  = 1'b0;
    rx_set_parity = 1'b0;
    if (tick && rx_state != RX_IDLE && rx_state != RX_WAIT) rx_tcnt_n = rx_tcnt + 4'd1;
    case (rx_state)
      RX_IDLE: if (!rx_sync) begin
        rx_state_n = RX_START;
        rx_tcnt_n  = 4'd0;
      end
      RX_START: if (tick && rx_tcnt == 4'd7) begin
        rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
        rx_tcnt_n  = 4'd0;
        rx_bit_n   = 3'd0;
      end
      RX_DATA: if (rx_bit_end) begin
        rx_shift_n = {rx_sync, rx_shift[7:1]};
        if (rx_bit == 3'd7) rx_state_n = par_en ? RX_PARITY : RX_STOP;
        else                rx_bit_n   = rx_bit + 3'd1;
      end
      RX_PARITY: if (rx_bit_end) begin
        rx_set_parity = (rx_sync != ((^rx_shift) ^ par_odd));
        rx_state_n    = RX_STOP;
      end
      RX_STOP: if (rx_bit_end) begin
        if (rx_sync) begin
          rx_push    = 1'b1;
          rx_state_n = RX_IDLE;
        end else begin
          rx_set_frame = 1'b1;
          rx_state_n   = RX_WAIT;
        end
      end
      RX_WAIT: if (rx_sync) rx_state_n = RX_IDLE;
      default: rx_state_n = RX_IDLE;
    endcase
    if (!ctrl[1]) rx_state_n = RX_IDLE;
  end

  // New error events take priority over a same-cycle write-1-to-clear.
  assign sticky_set = {wr_data & tx_full, rx_set_parity, rx_set_frame,
                       rx_push & rx_full & !rx_pop};
  assign sticky_clr = wr_stat ? HWDATA[8:5] : 4'd0;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sticky   <= 4'd0;
      uart_irq <= 1'b0;
    end else begin
      sticky   <= (sticky & ~sticky_clr) | sticky_set;
      uart_irq <= (ctrl[5] & !rx_empty) | (ctrl[6] & tx_empty & !tx_busy) |
                  (ctrl[7] & (|sticky));
    end
  end

  assign status = {sticky, tx_busy, rx_full, tx_empty, tx_full, rx_empty};

  always_comb begin
    HRDATA = 32'd0;
    if (dp_valid && !dp_write) begin
      case (dp_addr)
        2'd0: HRDATA = rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rp[FIFO_AW-1:0]]};
        2'd1: HRDATA = {23'd0, status};
        2'd2: HRDATA = {24'd0, ctrl};
        default: HRDATA = {16'd0, bauddiv};
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_uart_cfg.sv
// Directed self-checking bench for ahb_uart_cfg: TX waveforms, loopback, FIFO overflow,
// RX error injection and reset during a frame.
module tb_ahb_uart_cfg;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        RsRx;
  logic        RsTx;
  logic        uart_irq;

  logic         loop_en;
  logic         rx_drv;
  logic [399:0] wave;
  int           n_checks;
  int           n_fails;

  assign RsRx = loop_en ? RsTx : rx_drv;

  always #5 HCLK = ~HCLK;

  ahb_uart_cfg #(.FIFO_AW(4), .DEFAULT_DIV(16'd26)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
    .HRDATA(HRDATA), .RsRx(RsRx), .RsTx(RsTx), .uart_irq(uart_irq)
  );

  task automatic ahb_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {28'd0, a};
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    @(negedge HCLK);
  endtask

  task automatic ahb_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {28'd0, a};
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00;
    d = HRDATA;
  endtask

  // Record RsTx from the first low sample onward; optionally read STATUS with data
  // phases at offsets rd_at and rd_at+1.
  task automatic capture(input int rd_at, output logic [31:0] st_a, output logic [31:0] st_b,
                         output bit found);
    int w;
    found = 1'b0; w = 0; st_a = 32'd0; st_b = 32'd0;
    while (w < 200 && !found) begin
      @(negedge HCLK);
      if (RsTx === 1'b0) found = 1'b1;
      else w++;
    end
    if (found) begin
      for (int k = 0; k < 400; k++) begin
        if (k > 0) @(negedge HCLK);
        wave[k] = RsTx;
        if (k == rd_at)     st_a = HRDATA;
        if (k == rd_at + 1) st_b = HRDATA;
        if (k == rd_at - 1 || k == rd_at) begin
          HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h4;
        end else begin
          HSEL = 1'b0; HTRANS = 2'b00;
        end
      end
    end
  endtask

  function automatic logic [399:0] build_frame(input logic [7:0] d, input int par);
    logic [399:0] v;
    v = '1;
    for (int i = 0; i < 16; i++) v[i] = 1'b0;
    for (int b = 0; b < 8; b++)
      for (int i = 0; i < 16; i++) v[16 + 16*b + i] = d[b];
    if (par != 0)
      for (int i = 0; i < 16; i++) v[144 + i] = (^d) ^ (par == 2);
    return v;
  endfunction

  // One bit lasts 64 clocks with BAUDDIV=3.
  task automatic send_rx(input logic [7:0] d, input logic stop_bit);
    rx_drv = 1'b0;
    repeat (64) @(negedge HCLK);
    for (int b = 0; b < 8; b++) begin
      rx_drv = d[b];
      repeat (64) @(negedge HCLK);
    end
    rx_drv = stop_bit;
    repeat (64) @(negedge HCLK);
    rx_drv = 1'b1;
    repeat (64) @(negedge HCLK);
  endtask

  task automatic test_reset;
    logic [31:0] r;
    n_checks++;
    if (RsTx !== 1'b1) begin n_fails++; $display("[TB] FAIL reset_rstx got %b want 1", RsTx); end
    n_checks++;
    if (uart_irq !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_irq got %b want 0", uart_irq); end
    n_checks++;
    if (HRDATA !== 32'd0) begin n_fails++; $display("[TB] FAIL reset_hrdata got %h want 0", HRDATA); end
    n_checks++;
    if (HREADYOUT !== 1'b1) begin n_fails++; $display("[TB] FAIL hreadyout got %b want 1", HREADYOUT); end
    ahb_read(4'h4, r);
    n_checks++;
    if (r !== 32'h005) begin n_fails++; $display("[TB] FAIL reset_status got %h want 005", r); end
    ahb_read(4'h8, r);
    n_checks++;
    if (r !== 32'h03) begin n_fails++; $display("[TB] FAIL reset_ctrl got %h want 03", r); end
    ahb_read(4'hC, r);
    n_checks++;
    if (r !== 32'd26) begin n_fails++; $display("[TB] FAIL reset_baud got %0d want 26", r); end
  endtask

  task automatic test_tx_waveform;
    logic [31:0] sa, sb;
    logic [399:0] ev;
    bit found;
    ahb_write(4'hC, 32'd0);
    ahb_write(4'h0, 32'hA5);
    capture(159, sa, sb, found);
    ev = build_frame(8'hA5, 0);
    n_checks++;
    if (!found) begin n_fails++; $display("[TB] FAIL tx_start_seen got 0 want 1"); end
    n_checks++;
    if (wave[175:0] !== ev[175:0]) begin
      n_fails++; $display("[TB] FAIL tx_8n1_wave got %h want %h", wave[175:0], ev[175:0]);
    end
    n_checks++;
    if (sa !== 32'h015) begin n_fails++; $display("[TB] FAIL tx_busy_159 got %h want 015", sa); end
    n_checks++;
    if (sb !== 32'h005) begin n_fails++; $display("[TB] FAIL tx_busy_160 got %h want 005", sb); end
  endtask

  task automatic test_parity_stop;
    logic [31:0] sa, sb;
    logic [399:0] ev;
    bit found;
    ahb_write(4'h8, 32'h16);
    ahb_write(4'h0, 32'h07);
    ahb_write(4'h0, 32'h07);
    ahb_write(4'h8, 32'h17);
    capture(-10, sa, sb, found);
    ev = build_frame(8'h07, 1);
    n_checks++;
    if (!found) begin n_fails++; $display("[TB] FAIL even_start_seen got 0 want 1"); end
    n_checks++;
    if (wave[191:0] !== ev[191:0]) begin
      n_fails++; $display("[TB] FAIL even_2stop_wave got %h want %h", wave[191:0], ev[191:0]);
    end
    n_checks++;
    if (wave[152] !== 1'b1) begin n_fails++; $display("[TB] FAIL even_parity_bit got %b want 1", wave[152]); end
    n_checks++;
    if (wave[207:192] !== 16'h0000) begin
      n_fails++; $display("[TB] FAIL second_start_after_2stop got %h want 0000", wave[207:192]);
    end
    ahb_write(4'h8, 32'h0A);
    ahb_write(4'h0, 32'h07);
    ahb_write(4'h8, 32'h0B);
    capture(-10, sa, sb, found);
    ev = build_frame(8'h07, 2);
    n_checks++;
    if (wave[199:0] !== ev[199:0]) begin
      n_fails++; $display("[TB] FAIL odd_wave got %h want %h", wave[199:0], ev[199:0]);
    end
    n_checks++;
    if (wave[152] !== 1'b0) begin n_fails++; $display("[TB] FAIL odd_parity_bit got %b want 0", wave[152]); end
  endtask

  task automatic test_loopback;
    logic [31:0] r;
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h3C; exp_b[1] = 8'hFF; exp_b[2] = 8'h00;
    ahb_write(4'h8, 32'h03);
    ahb_write(4'hC, 32'd3);
    loop_en = 1'b1;
    for (int i = 0; i < 3; i++) ahb_write(4'h0, {24'd0, exp_b[i]});
    repeat (2400) @(negedge HCLK);
    ahb_read(4'h4, r);
    n_checks++;
    if (r !== 32'h004) begin n_fails++; $display("[TB] FAIL loop_status got %h want 004", r); end
    ahb_write(4'h8, 32'h23);
    @(negedge HCLK);
    n_checks++;
    if (uart_irq !== 1'b1) begin n_fails++; $display("[TB] FAIL loop_irq_set got %b want 1", uart_irq); end
    for (int i = 0; i < 3; i++) begin
      ahb_read(4'h0, r);
      n_checks++;
      if (r !== {24'd0, exp_b[i]}) begin
        n_fails++; $display("[TB] FAIL loop_data%0d got %h want %h", i, r, exp_b[i]);
      end
    end
    ahb_read(4'h0, r);
    n_checks++;
    if (r !== 32'd0) begin n_fails++; $display("[TB] FAIL loop_empty_read got %h want 0", r); end
    @(negedge HCLK);
    n_checks++;
    if (uart_irq !== 1'b0) begin n_fails++; $display("[TB] FAIL loop_irq_clear got %b want 0", uart_irq); end
    ahb_read(4'h4, r);
    n_checks++;
    if (r !== 32'h005) begin n_fails++; $display("[TB] FAIL loop_status_end got %h want 005", r); end
    loop_en = 1'b0;
  endtask

  task automatic test_tx_overflow;
    logic [31:0] r;
    logic prev;
    int falls;
    ahb_write(4'h8, 32'h02);
    ahb_write(4'hC, 32'd0);
    for (int i = 0; i < 17; i++) ahb_write(4'h0, 32'hFF);
    ahb_read(4'h4, r);
    n_checks++;
    if (r !== 32'h103) begin n_fails++; $display("[TB] FAIL ovf_status got %h want 103", r); end
    ahb_write(4'h8, 32'h03);
    falls = 0;
    prev = RsTx;
    for (int k = 0; k < 3000; k++) begin
      @(negedge HCLK);
      if (prev === 1'b1 && RsTx === 1'b0) falls++;
      prev = RsTx;
    end
    n_checks++;
    if (falls !== 16) begin n_fails++; $display("[TB] FAIL ovf_frames got %0d want 16", falls); end
    ahb_read(4'h4, r);
    n_checks++;
    if (r !== 32'h105) begin n_fails++; $display("[TB] FAIL ovf_status_drained got %h want 105", r); end
    ahb_write(4'h4, 32'h100);
    ahb_read(4'h4, r);
    n_checks++;
    if (r !== 32'h005) begin n_fails++; $display("[TB] FAIL ovf_w1c got %h want 005", r); end
  endtask

  task automatic test_rx_errors;
    logic [31:0] r;
    ahb_write(4'hC, 32'd3);
    send_rx(8'h55, 1'b0);
    ahb_read(4'h4, r);
    n_checks++;
    if (r !== 32'h045) begin n_fails++; $display("[TB] FAIL frame_err_status got %h want 045", r); end
    ahb_write(4'h4, 32'h1E0);
    ahb_read(4'h4, r);
    n_checks++;
    if (r !== 32'h005) begin n_fails++; $display("[TB] FAIL frame_err_clear got %h want 005", r); end
    rx_drv = 1'b0;
    repeat (4) @(negedge HCLK);
    rx_drv = 1'b1;
    repeat (100) @(negedge HCLK);
    ahb_read(4'h4, r);
    n_checks++;
    if (r !== 32'h005) begin n_fails++; $display("[TB] FAIL glitch_status got %h want 005", r); end
    for (int i = 0; i < 17; i++) send_rx(8'h10 + 8'(i), 1'b1);
    ahb_read(4'h4, r);
    n_checks++;
    if (r !== 32'h02C) begin n_fails++; $display("[TB] FAIL overrun_status got %h want 02c", r); end
    ahb_write(4'h8, 32'h83);
    @(negedge HCLK);
    n_checks++;
    if (uart_irq !== 1'b1) begin n_fails++; $display("[TB] FAIL overrun_irq got %b want 1", uart_irq); end
    ahb_read(4'h0, r);
    n_checks++;
    if (r !== 32'h10) begin n_fails++; $display("[TB] FAIL overrun_first_byte got %h want 10", r); end
  endtask

  task automatic test_reset_mid_tx;
    logic [31:0] r;
    ahb_write(4'h0, 32'h00);
    repeat (100) @(negedge HCLK);
    n_checks++;
    if (RsTx !== 1'b0) begin n_fails++; $display("[TB] FAIL midtx_line_low got %b want 0", RsTx); end
    HRESET = 1'b1;
    @(negedge HCLK);
    n_checks++;
    if (RsTx !== 1'b1) begin n_fails++; $display("[TB] FAIL midtx_reset_line got %b want 1", RsTx); end
    n_checks++;
    if (uart_irq !== 1'b0) begin n_fails++; $display("[TB] FAIL midtx_reset_irq got %b want 0", uart_irq); end
    HRESET = 1'b0;
    ahb_read(4'h4, r);
    n_checks++;
    if (r !== 32'h005) begin n_fails++; $display("[TB] FAIL midtx_status got %h want 005", r); end
    ahb_read(4'h8, r);
    n_checks++;
    if (r !== 32'h03) begin n_fails++; $display("[TB] FAIL midtx_ctrl got %h want 03", r); end
    ahb_read(4'hC, r);
    n_checks++;
    if (r !== 32'd26) begin n_fails++; $display("[TB] FAIL midtx_baud got %0d want 26", r); end
  endtask

  initial begin
    n_checks = 0; n_fails = 0;
    HRESET = 1'b1; HSEL = 1'b0; HADDR = 32'd0; HTRANS = 2'b00; HWRITE = 1'b0;
    HWDATA = 32'd0; HREADY = 1'b1; loop_en = 1'b0; rx_drv = 1'b1; wave = '1;
    repeat (3) @(negedge HCLK);
    HRESET = 1'b0;
    @(negedge HCLK);
    $display("[TB] starting directed tests");
    test_reset();
    test_tx_waveform();
    test_parity_stop();
    test_loopback();
    test_tx_overflow();
    test_rx_errors();
    test_reset_mid_tx();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/ahb_uart_cfg.md
Name: ahb_uart_cfg

Overview:
- AHB-Lite slave UART, successor to the fixed-rate UART peripheral on the Cortex-M3 system bus.
- Adds a programmable baud divisor, optional even/odd parity, 1 or 2 TX stop bits, and parametrised FIFO depth.
- Adds sticky error flags (overrun, frame, parity, TX overflow) and a masked interrupt.
- Never stalls the bus. Sits on the AHB decoder/mux like other peripherals and drives one IRQ line to the NVIC.

Parameters:
- FIFO_AW, 4, log2 of TX and RX FIFO depth (depth = 2^FIFO_AW).
- DEFAULT_DIV, 16'd26, reset value of BAUDDIV (50 MHz clock, 115200 baud, 16x oversampling).

Ports:
- HCLK  input  1  system clock.
- HRESET  input  1  synchronous active-high reset.
- HSEL  input  1  slave select.
- HADDR  input  32  address; only [3:2] decoded.
- HTRANS  input  2  transfer type; HTRANS[1] = active.
- HWRITE  input  1  write strobe.
- HWDATA  input  32  write data, data phase.
- HREADY  input  1  bus ready.
- HREADYOUT  output  1  tied 1.
- HRDATA  output  32  read data.
- RsRx  input  1  serial in, asynchronous.
- RsTx  output  1  serial out.
- uart_irq  output  1  level interrupt.

Behaviour:
- Reset state:
  - RsTx=1, uart_irq=0, HRDATA=0, both FIFOs empty, sticky flags 0.
  - CTRL=0x03, BAUDDIV=DEFAULT_DIV, both FSMs in IDLE.
- AHB address phase: captured when HREADY & HSEL & HTRANS[1]; holds HADDR[3:2] and HWRITE.
- AHB data phase: the next cycle.
  - Write: uses HWDATA in the data phase.
  - Read: HRDATA is combinational from the captured address, and 0 when no read is in its data phase.
- Register map (offsets):
  - 0x0: DATA.
    - Write pushes HWDATA[7:0] to TX FIFO.
    - Read returns {24'b0, RX head} and pops in the same cycle. Returns 0 with no pop if RX is empty.
  - 0x4: STATUS, read.
    - bit0 rx_empty, bit1 tx_full, bit2 tx_empty, bit3 rx_full, bit4 tx_busy.
    - Sticky: bit5 rx_overrun, bit6 frame_err, bit7 parity_err, bit8 tx_overflow.
    - Write-1-to-clear bits 5-8.
  - 0x8: CTRL, R/W, bits 7:0.
    - bit0 tx_en, bit1 rx_en.
    - bits3:2 parity: 00/11 none, 01 even, 10 odd.
    - bit4 two TX stop bits.
    - bit5 rx_ie, bit6 tx_ie, bit7 err_ie.
  - 0xC: BAUDDIV, R/W, bits 15:0. Writing it resets the divider counter to 0.
- Baud divider: oversample tick pulses 1 cycle every BAUDDIV+1 clocks. Each bit period = 16 ticks.
- TX write to full FIFO: byte dropped, tx_overflow set.
- RX push to full FIFO with no same-cycle pop: byte dropped, rx_overrun set. Push and pop in the same cycle when full: both succeed.
- FIFOs: circular pointers with FIFO_AW+1 bits; wrap-around is seamless.
- TX FSM: IDLE -> START -> DATA(8, LSB first) -> PARITY (skipped if none) -> STOP (1 or 2 bits) -> IDLE.
  - Leaves IDLE only when tx_en & !tx_empty and on a tick boundary. Pops the FIFO and latches the byte on entry to START.
  - tx_busy = state != IDLE.
  - Clearing tx_en mid-frame finishes the current frame, then holds in IDLE.
  - Back-to-back frames: no idle gap beyond tick alignment.
  - Parity bit: even = XOR of data bits; odd = its inverse.
- RX FSM:
  - RsRx passes through a 2-flop synchroniser.
  - IDLE -> START on a falling level while rx_en.
  - START: resample after 8 ticks. If high, treat as a glitch and return to IDLE. Otherwise -> DATA.
  - DATA: sample every 16 ticks, 8 bits LSB first.
  - PARITY: sample when enabled; a mismatch sets parity_err and the byte is still pushed.
  - STOP: sample one stop bit. If 0, set frame_err, discard the byte, and return to IDLE only after the line goes high. If 1, push the byte and return to IDLE.
  - Clearing rx_en returns the FSM to IDLE immediately; a partial byte is discarded.
- IRQ: uart_irq = (rx_ie & !rx_empty) | (tx_ie & tx_empty & !tx_busy) | (err_ie & |sticky[8:5]). Registered, so it updates 1 cycle after its cause.
- Sticky write-1-to-clear and a new error event in the same cycle: the set wins.
- HRESET asserted mid-frame: RsTx=1 on the next edge and all state is lost.

Test Plan:
- Waveform, 8N1: BAUDDIV=0, CTRL=0x03, write DATA=0xA5 -> RsTx low 16 clocks, then bits 1,0,1,0,0,1,0,1 at 16 clocks each, then high. tx_busy deasserts 160 clocks after the START bit begins.
- Parity/stop: CTRL=0x17 (even parity, 2 stop), write 0x07 -> parity bit 1, stop high for 32 clocks. With CTRL=0x0B (odd), the parity bit is 0.
- Loopback: RsTx tied to RsRx, BAUDDIV=3, write 0x3C, 0xFF, 0x00 -> STATUS.rx_empty=0, DATA reads return 0x3C, 0xFF, 0x00, then 0 with rx_empty=1. rx_ie=1 makes uart_irq track rx_empty.
- Overflow: tx_en=0, write 17 bytes -> tx_full=1, tx_overflow=1, 16 bytes are transmitted after tx_en=1. Write STATUS=0x100 -> bit8 clears.
- RX errors:
  - Inject a frame with stop=0 -> frame_err=1, no push.
  - Inject a 4-clock low glitch -> no state change.
  - Inject 17 frames with no reads -> rx_overrun=1, with err_ie=1 uart_irq=1.
- Reset mid-TX: assert HRESET during DATA bits -> RsTx=1 next cycle, STATUS=0x005, CTRL=0x03, BAUDDIV=26.
